ysyx_23060061_lsu: RTL and testbench
====================================

# ysyx_23060061_lsu

Load/store unit that sits directly downstream of the instruction decoder. It consumes the decoder's memory controls (`MemRW`, `memExt`, `wmask`) together with the ALU-computed address and the store data from rs2. It runs one data-memory transaction at a time over a valid/ready request and response interface. It returns load data, aligned and sign- or zero-extended, to the write-back mux (`WBSel` = 00).

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width. Fixed at 32; `wmask` and `mem_wstrb` are 4 bits.

Clocking: one clock; reset is synchronous and active-high. Ports are named `clk` and `rst`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `req_valid`  in  1  core presents a memory instruction
- `req_ready`  out  1  LSU can accept a request
- `MemRW`  in  2  00 idle, 10 read, 01 write, 11 treated as idle
- `memExt`  in  3  000 word, 001 sext byte, 010 sext half, 011 zext byte, 100 zext half, 101–111 treated as word
- `wmask`  in  4  store byte mask, low-aligned: 0001 sb, 0011 sh, 1111 sw
- `addr`  in  ADDR_W  byte address from the ALU
- `wdata`  in  32  store data (rs2), low-aligned
- `resp_valid`  out  1  one-cycle completion pulse
- `rdata`  out  32  extended load data, valid with `resp_valid`
- `misalign`  out  1  pulses together with `resp_valid` when the access was rejected
- `mem_req_valid`  out  1  memory request valid
- `mem_req_ready`  in  1  memory accepts the request
- `mem_wen`  out  1  1 = write
- `mem_addr`  out  ADDR_W  word-aligned address, `{addr[ADDR_W-1:2],2'b00}`
- `mem_wdata`  out  32  `wdata << (8*addr[1:0])`
- `mem_wstrb`  out  4  `wmask << addr[1:0]`
- `mem_resp_valid`  in  1  memory completion (both reads and writes)
- `mem_rdata`  in  32  raw word read from memory

## Operation
FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch `MemRW`, `memExt`, `wmask`, `addr` and `wdata`.
  - If `MemRW` is 00 or 11, or the access is misaligned, go to RESP. No memory access is made.
  - Otherwise go to REQ.
- **Misaligned** means:
  - half access (`wmask`=0011, or `memExt` ∈ {010,100}) with `addr[0]`=1; or
  - word access with `addr[1:0]` ≠ 0.
  - The access is then dropped: `misalign`=1, `rdata`=0.
- **REQ**
  - `mem_req_valid` = 1; all `mem_*` outputs are driven from the latched values and stay stable.
  - Go to WAIT on `mem_req_ready`.
- **WAIT**
  - `mem_req_valid` = 0.
  - On `mem_resp_valid`, latch the load result and go to RESP.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle, then go to IDLE.
- **Load result**
  - `shifted = mem_rdata >> (8*addr[1:0])`, then extend per `memExt`.
  - For writes and idle requests, `rdata` = 0.
- `mem_resp_valid` is ignored in every state except WAIT.
- `mem_req_ready` is ignored in every state except REQ.

## Timing
- **Reset**
  - State goes to IDLE.
  - All registered outputs and latches clear to 0: `resp_valid`, `rdata`, `misalign`, `mem_req_valid`, `mem_wen`, `mem_addr`, `mem_wdata`, `mem_wstrb`.
  - `req_ready` = 1 from the first cycle after reset.
- `req_ready` is combinational: `state == IDLE`.
- **Best case** (`mem_req_ready`=1 on the first REQ cycle, `mem_resp_valid` on the first WAIT cycle):
  - accept at cycle N;
  - `mem_req_valid` at cycle N+1;
  - response at cycle N+2;
  - `resp_valid` at cycle N+3.
- Idle or misaligned request: `resp_valid` at cycle N+1.
- Each stall cycle on `mem_req_ready` or `mem_resp_valid` adds one cycle. There is no timeout.
- Throughput: at most one request outstanding. The earliest next accept is the cycle after RESP.
- **Reset mid-transaction**
  - State is abandoned and `mem_req_valid` drops on the next edge.
  - A late `mem_resp_valid` then lands in IDLE and is ignored.
  - The memory model is expected to be reset together with the LSU.

## Structure
- Encodings go in `global.vh` as `ysyx_23060061_` defines: `MemRW` values, `memExt` values, and FSM state codes (2 bits).
- One combinational sub-module, `ysyx_23060061_load_align`, takes (`mem_rdata`, `addr[1:0]`, `memExt`) and produces `rdata`. It is reusable by the difftest model.
- Store alignment (shift and strobe) stays inline.

## Test plan
- **sw**: `addr`=0x8000_0004, `wdata`=0xDEAD_BEEF, `wmask`=1111 → `mem_addr`=0x8000_0004, `mem_wstrb`=1111, `mem_wdata`=0xDEAD_BEEF, `mem_wen`=1; `resp_valid` at N+3 with zero-wait memory.
- **sb at offset 3**: `addr`=0x8000_0003, `wdata`=0x0000_00A5, `wmask`=0001 → `mem_addr`=0x8000_0000, `mem_wstrb`=1000, `mem_wdata`=0xA500_0000.
- **lb / lbu / lh / lhu** with `mem_rdata`=0x80FF_7F01:
  - `addr[1:0]`=2, `memExt`=001 → `rdata`=0xFFFF_FFFF;
  - `addr[1:0]`=3, `memExt`=011 → `rdata`=0x0000_0080;
  - `addr[1:0]`=2, `memExt`=010 → `rdata`=0xFFFF_80FF;
  - `addr[1:0]`=0, `memExt`=100 → `rdata`=0x0000_7F01.
- **Backpressure**: hold `mem_req_ready`=0 for 3 cycles, then delay `mem_resp_valid` by 2 cycles → `mem_*` outputs stable throughout REQ, `req_ready`=0 throughout, exactly one `resp_valid` at N+8.
- **Misaligned and idle requests**: lw at 0x8000_0002 → `misalign`=1 with `resp_valid` at N+1, `mem_req_valid` never asserted; `MemRW`=00 → `resp_valid` at N+1, `rdata`=0.
- **Reset mid-transaction**: assert `rst` during WAIT, then pulse `mem_resp_valid` the cycle after → state IDLE, no `resp_valid`, `req_ready`=1.

Source files
------------

// File: rtl/ysyx_23060061_lsu_pkg.sv
// ysyx_23060061_lsu_pkg
// Shared encodings for the load/store unit: MemRW and memExt codes, FSM
// state codes, and the misalignment rule used when a request is accepted.
package ysyx_23060061_lsu_pkg;

  // MemRW encodings; 00 and 11 both mean "no memory access"
  localparam logic [1:0] MEMRW_READ  = 2'b10;
  localparam logic [1:0] MEMRW_WRITE = 2'b01;

  // memExt encodings; 000 and 101-111 all mean "word"
  localparam logic [2:0] EXT_SB = 3'b001;
  localparam logic [2:0] EXT_SH = 3'b010;
  localparam logic [2:0] EXT_ZB = 3'b011;
  localparam logic [2:0] EXT_ZH = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  // Stores size the access by wmask, loads by memExt. Half accesses need
  // addr[0]=0, word accesses need addr[1:0]=0, bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] memrw,
                                         input logic [2:0] ext,
                                         input logic [3:0] wmask,
                                         input logic [1:0] off);
    logic half;
    logic word;
    if (memrw == MEMRW_WRITE) begin
      half = (wmask == 4'b0011);
      word = (wmask == 4'b1111);
    end else begin
      half = (ext == EXT_SH) || (ext == EXT_ZH);
      word = !(half || (ext == EXT_SB) || (ext == EXT_ZB));
    end
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060061_lsu_load_align.sv
// ysyx_23060061_load_align
// Purely combinational load aligner: shifts the raw memory word down by the
// byte offset, then sign- or zero-extends per memExt. Shared with the
// difftest reference model.
// Ports:
//   mem_rdata_i  raw 32-bit word from memory
//   offset_i     addr[1:0] of the load
//   mem_ext_i    memExt code
//   rdata_o      aligned, extended load result
module ysyx_23060061_load_align
  import ysyx_23060061_lsu_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  mem_ext_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted_s;

  // Move the addressed byte/half into the low bits, then extend it
  always_comb begin
    shifted_s = mem_rdata_i >> {offset_i, 3'b000};
    case (mem_ext_i)
      EXT_SB:  rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      EXT_SH:  rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      EXT_ZB:  rdata_o = {24'h00_0000, shifted_s[7:0]};
      EXT_ZH:  rdata_o = {16'h0000, shifted_s[15:0]};
      default: rdata_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/ysyx_23060061_lsu.sv
// ysyx_23060061_lsu
// Load/store unit: accepts one decoded memory instruction at a time, issues a
// single word-aligned memory transaction, and returns extended load data.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       core request handshake (ready = FSM idle)
//   MemRW, memExt, wmask      decoded memory controls
//   addr, wdata               byte address and low-aligned store data
//   resp_valid, rdata         one-cycle completion with load result
//   misalign                  completion was a rejected misaligned access
//   mem_req_valid/ready       memory request handshake
//   mem_wen, mem_addr         write enable, word-aligned address
//   mem_wdata, mem_wstrb      lane-shifted store data and byte strobes
//   mem_resp_valid, mem_rdata memory completion and raw read word
module ysyx_23060061_lsu
  import ysyx_23060061_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        MemRW,
  input  logic [2:0]        memExt,
  input  logic [3:0]        wmask,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q;
  logic [1:0]        memrw_q;
  logic [2:0]        ext_q;
  logic [1:0]        off_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              misalign_q;
  logic              mem_req_valid_q;
  logic              mem_wen_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [3:0]        mem_wstrb_q;

  logic              access_s;
  logic              misalign_s;
  logic [DATA_W-1:0] align_rdata_s;

  assign access_s   = (MemRW == MEMRW_READ) || (MemRW == MEMRW_WRITE);
  assign misalign_s = access_s && is_misaligned(MemRW, memExt, wmask, addr[1:0]);

  // Aligner works on the latched offset/extension so the request inputs may
  // change freely once accepted.
  ysyx_23060061_load_align u_load_align (
    .mem_rdata_i (mem_rdata),
    .offset_i    (off_q),
    .mem_ext_i   (ext_q),
    .rdata_o     (align_rdata_s)
  );

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      memrw_q         <= 2'b00;
      ext_q           <= 3'b000;
      off_q           <= 2'b00;
      resp_valid_q    <= 1'b0;
      rdata_q         <= '0;
      misalign_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_wen_q       <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            memrw_q     <= MemRW;
            ext_q       <= memExt;
            off_q       <= addr[1:0];
            rdata_q     <= '0;
            mem_wen_q   <= (MemRW == MEMRW_WRITE);
            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
            mem_wdata_q <= wdata << {addr[1:0], 3'b000};
            mem_wstrb_q <= wmask << addr[1:0];
            misalign_q  <= misalign_s;
            if (access_s && !misalign_s) begin
              state_q         <= ST_REQ;
              mem_req_valid_q <= 1'b1;
            end else begin
              // Idle and rejected requests complete without touching memory
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state_q         <= ST_WAIT;
            mem_req_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= (memrw_q == MEMRW_READ) ? align_rdata_s : '0;
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
        end
        default: begin
          state_q         <= ST_IDLE;
          resp_valid_q    <= 1'b0;
          mem_req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = resp_valid_q;
  assign rdata         = rdata_q;
  assign misalign      = misalign_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_wen       = mem_wen_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
module tb_ysyx_23060061_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  MemRW;
  logic [2:0]  memExt;
  logic [3:0]  wmask;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misalign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  ysyx_23060061_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .MemRW          (MemRW),
    .memExt         (memExt),
    .wmask          (wmask),
    .addr           (addr),
    .wdata          (wdata),
    .resp_valid     (resp_valid),
    .rdata          (rdata),
    .misalign       (misalign),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  rw;
    logic [2:0]  ext;
    logic [3:0]  wm;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    int          rstall;
    int          pstall;
    logic [31:0] e_rdata;
    logic        e_mis;
    logic        e_mem;
    logic        e_wen;
    logic [31:0] e_maddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int   c0;
    int   rs;
    int   ws;
    bit   hs;
    bit   rsent;
    bit   done;
    @(negedge clk);
    chk("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    MemRW     = v.rw;
    memExt    = v.ext;
    wmask     = v.wm;
    addr      = v.addr;
    wdata     = v.wd;
    mem_rdata = v.mrd;
    e.rdata   = v.e_rdata;
    e.mis     = v.e_mis;
    e.lat     = v.e_mem ? (3 + v.rstall + v.pstall) : 1;
    sb_q.push_back(e);
    c0    = cyc;
    rs    = 0;
    ws    = 0;
    hs    = 1'b0;
    rsent = 1'b0;
    done  = 1'b0;
    @(posedge clk);
    #1;
    // Scramble request inputs so the DUT must rely on its latched copies
    req_valid = 1'b0;
    MemRW     = 2'b11;
    memExt    = 3'b111;
    wmask     = 4'b0101;
    addr      = 32'hFFFF_FFFF;
    wdata     = 32'h5A5A_5A5A;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      chk("busy_ready", {31'd0, req_ready}, 32'd0);
      if (resp_valid) begin
        done = 1'b1;
        if (sb_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
          chk("latency", cyc - c0, e.lat);
        end
      end
      if (mem_req_valid) begin
        if (!v.e_mem) begin
          chk("spurious_mem_req", 32'd1, 32'd0);
        end else begin
          chk("mem_wen", {31'd0, mem_wen}, {31'd0, v.e_wen});
          chk("mem_addr", mem_addr, v.e_maddr);
          if (v.e_wen) begin
            chk("mem_wdata", mem_wdata, v.e_wdata);
            chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, v.e_wstrb});
          end
        end
        mem_req_ready  = (rs >= v.rstall);
        if (mem_req_ready) hs = 1'b1;
        rs++;
        mem_resp_valid = 1'b0;
      end else begin
        mem_req_ready = 1'b0;
        if (hs && !rsent) begin
          mem_resp_valid = (ws >= v.pstall);
          if (mem_resp_valid) rsent = 1'b1;
          ws++;
        end else begin
          mem_resp_valid = 1'b0;
        end
      end
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    if (!done) begin
      chk("resp_timeout", 32'd1, 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
    chk("single_pulse", {31'd0, resp_valid}, 32'd0);
    chk("misalign_clear", {31'd0, misalign}, 32'd0);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    // rw, ext, wm, addr, wd, mrd, rstall, pstall, e_rdata, e_mis, e_mem, e_wen, e_maddr, e_wdata, e_wstrb
    vecs[0]  = '{2'b01, 3'b000, 4'b1111, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0,
                 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111};
    vecs[1]  = '{2'b01, 3'b000, 4'b0001, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0,
                 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hA500_0000, 4'b1000};
    vecs[2]  = '{2'b10, 3'b001, 4'b0000, 32'h8000_0002, 32'h0, 32'h80FF_7F01, 0, 0,
                 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000};
    vecs[3]  = '{2'b10, 3'b011, 4'b0000, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 0, 0,
                 32'h0000_0080, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000};
    vecs[4]  = '{2'b10, 3'b010, 4'b0000, 32'h8000_0002, 32'h0, 32'h80FF_7F01, 0, 0,
                 32'hFFFF_80FF, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000};
    vecs[5]  = '{2'b10, 3'b100, 4'b0000, 32'h8000_0000, 32'h0, 32'h80FF_7F01, 0, 0,
                 32'h0000_7F01, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000};
    vecs[6]  = '{2'b10, 3'b000, 4'b0000, 32'h8000_0008, 32'h0, 32'h1234_5678, 3, 2,
                 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'b0000};
    vecs[7]  = '{2'b10, 3'b000, 4'b0000, 32'h8000_0002, 32'h0, 32'hCAFE_F00D, 0, 0,
                 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[8]  = '{2'b00, 3'b000, 4'b0000, 32'h8000_0000, 32'h0, 32'hCAFE_F00D, 0, 0,
                 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[9]  = '{2'b11, 3'b000, 4'b1111, 32'h8000_0000, 32'h1111_2222, 32'hCAFE_F00D, 0, 0,
                 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[10] = '{2'b01, 3'b000, 4'b0011, 32'h8000_0001, 32'h0000_1234, 32'h0, 0, 0,
                 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[11] = '{2'b01, 3'b000, 4'b0011, 32'h8000_0002, 32'h0000_1234, 32'h0, 1, 1,
                 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h1234_0000, 4'b1100};
    vecs[12] = '{2'b10, 3'b010, 4'b0000, 32'h8000_0005, 32'h0, 32'h80FF_7F01, 0, 0,
                 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000};

    rst            = 1'b1;
    req_valid      = 1'b0;
    MemRW          = 2'b00;
    memExt         = 3'b000;
    wmask          = 4'b0000;
    addr           = 32'h0;
    wdata          = 32'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      run(vecs[i]);
    end

    // Reset while waiting for the memory response; the late response must be ignored
    @(negedge clk);
    req_valid = 1'b1;
    MemRW     = 2'b10;
    memExt    = 3'b000;
    wmask     = 4'b0000;
    addr      = 32'h8000_0010;
    mem_rdata = 32'h7777_8888;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_req_valid", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("mid_wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("mid_wait_ready", {31'd0, req_ready}, 32'd0);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_resp_ignored", {31'd0, resp_valid}, 32'd0);
      chk("late_ready", {31'd0, req_ready}, 32'd1);
      chk("late_rdata", rdata, 32'd0);
      @(negedge clk);
    end

    // Normal traffic still works after the abandoned transaction
    run(vecs[4]);
    run(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
